// File: rtl/jt5205_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt5205_enc                                                           |
// | MSM5205-compatible ADPCM encoder: 12-bit signed PCM to 4-bit nibbles |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jt5205_enc #(
  parameter int STEP_INIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               sample,
  input  logic signed [11:0] pcm,
  output logic        [3:0]  dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               overrun,
  output logic signed [11:0] pred
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_B2   = 3'd2,
    S_B1   = 3'd3,
    S_B0   = 3'd4,
    S_UPD  = 3'd5
  } state_t;

  localparam logic [5:0] c_idx_init = 6'(STEP_INIT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [11:0] r_pcm;
  logic signed [11:0] r_pred;
  logic        [12:0] r_mag;
  logic               r_sign;
  logic               r_b2;
  logic               r_b1;
  logic        [5:0]  r_idx;
  logic        [3:0]  r_dout;
  logic               r_dout_valid;
  logic               r_overrun;

  logic        [11:0] w_step;
  logic        [11:0] w_cmp;
  logic               w_hit;
  logic signed [12:0] w_diff;
  logic        [12:0] w_abs;
  logic        [2:0]  w_code;
  logic        [13:0] w_q;
  logic signed [13:0] w_pred_ext;
  logic signed [13:0] w_sum;
  logic signed [11:0] w_pred_nxt;
  logic signed [6:0]  w_adj;
  logic signed [6:0]  w_idx_sum;
  logic        [5:0]  w_idx_nxt;

  function automatic logic [11:0] f_step(input logic [5:0] idx);
    case (idx)
      6'd0:  f_step = 12'd16;   6'd1:  f_step = 12'd17;   6'd2:  f_step = 12'd19;
      6'd3:  f_step = 12'd21;   6'd4:  f_step = 12'd23;   6'd5:  f_step = 12'd25;
      6'd6:  f_step = 12'd28;   6'd7:  f_step = 12'd31;   6'd8:  f_step = 12'd34;
      6'd9:  f_step = 12'd37;   6'd10: f_step = 12'd41;   6'd11: f_step = 12'd45;
      6'd12: f_step = 12'd50;   6'd13: f_step = 12'd55;   6'd14: f_step = 12'd60;
      6'd15: f_step = 12'd66;   6'd16: f_step = 12'd73;   6'd17: f_step = 12'd80;
      6'd18: f_step = 12'd88;   6'd19: f_step = 12'd97;   6'd20: f_step = 12'd107;
      6'd21: f_step = 12'd118;  6'd22: f_step = 12'd130;  6'd23: f_step = 12'd143;
      6'd24: f_step = 12'd157;  6'd25: f_step = 12'd173;  6'd26: f_step = 12'd190;
      6'd27: f_step = 12'd209;  6'd28: f_step = 12'd230;  6'd29: f_step = 12'd253;
      6'd30: f_step = 12'd279;  6'd31: f_step = 12'd307;  6'd32: f_step = 12'd337;
      6'd33: f_step = 12'd371;  6'd34: f_step = 12'd408;  6'd35: f_step = 12'd449;
      6'd36: f_step = 12'd494;  6'd37: f_step = 12'd544;  6'd38: f_step = 12'd598;
      6'd39: f_step = 12'd658;  6'd40: f_step = 12'd724;  6'd41: f_step = 12'd796;
      6'd42: f_step = 12'd876;  6'd43: f_step = 12'd963;  6'd44: f_step = 12'd1060;
      6'd45: f_step = 12'd1166; 6'd46: f_step = 12'd1282; 6'd47: f_step = 12'd1411;
      6'd48: f_step = 12'd1552;
      default: f_step = 12'd1552;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (cen) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (sample) w_state_nxt = S_DIFF;
      S_DIFF:  w_state_nxt = S_B2;
      S_B2:    w_state_nxt = S_B1;
      S_B1:    w_state_nxt = S_B0;
      S_B0:    w_state_nxt = S_UPD;
      S_UPD:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_step = f_step(r_idx);

  // One comparator serves all three bit decisions with the state-selected threshold
  always_comb begin
    w_cmp = w_step;
    case (r_state)
      S_B1:    w_cmp = {1'b0, w_step[11:1]};
      S_B0:    w_cmp = {2'b00, w_step[11:2]};
      default: w_cmp = w_step;
    endcase
  end

  assign w_hit  = (r_mag >= {1'b0, w_cmp});
  assign w_diff = {r_pcm[11], r_pcm} - {r_pred[11], r_pred};
  assign w_abs  = w_diff[12] ? (~w_diff + 13'd1) : w_diff;
  assign w_code = {r_b2, r_b1, w_hit};

  assign w_q = {5'd0, w_step[11:3]}
             + (r_b2  ? {2'd0, w_step}        : 14'd0)
             + (r_b1  ? {3'd0, w_step[11:1]}  : 14'd0)
             + (w_hit ? {4'd0, w_step[11:2]}  : 14'd0);

  assign w_pred_ext = {{2{r_pred[11]}}, r_pred};
  assign w_sum      = r_sign ? (w_pred_ext - $signed(w_q)) : (w_pred_ext + $signed(w_q));

  always_comb begin
    if (w_sum < -14'sd2048)     w_pred_nxt = 12'sh800;
    else if (w_sum > 14'sd2047) w_pred_nxt = 12'sh7ff;
    else                        w_pred_nxt = w_sum[11:0];
  end

  always_comb begin
    case (w_code)
      3'd4:    w_adj = 7'sd2;
      3'd5:    w_adj = 7'sd4;
      3'd6:    w_adj = 7'sd6;
      3'd7:    w_adj = 7'sd8;
      default: w_adj = -7'sd1;
    endcase
    w_idx_sum = $signed({1'b0, r_idx}) + w_adj;
    if (w_idx_sum < 7'sd0)       w_idx_nxt = 6'd0;
    else if (w_idx_sum > 7'sd48) w_idx_nxt = 6'd48;
    else                         w_idx_nxt = w_idx_sum[5:0];
  end

  // Results commit on leaving B0 so they are visible throughout the UPD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcm        <= 12'sd0;
      r_pred       <= 12'sd0;
      r_mag        <= 13'd0;
      r_sign       <= 1'b0;
      r_b2         <= 1'b0;
      r_b1         <= 1'b0;
      r_idx        <= c_idx_init;
      r_dout       <= 4'd0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (cen) begin
      r_overrun    <= sample && (r_state != S_IDLE);
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (sample) r_pcm <= pcm;
        S_DIFF: begin
          r_sign <= w_diff[12];
          r_mag  <= w_abs;
          r_b2   <= 1'b0;
          r_b1   <= 1'b0;
        end
        S_B2: if (w_hit) begin
          r_b2  <= 1'b1;
          r_mag <= r_mag - {1'b0, w_cmp};
        end
        S_B1: if (w_hit) begin
          r_b1  <= 1'b1;
          r_mag <= r_mag - {1'b0, w_cmp};
        end
        S_B0: begin
          r_dout       <= {r_sign, w_code};
          r_pred       <= w_pred_nxt;
          r_idx        <= w_idx_nxt;
          r_dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;
  assign pred       = r_pred;

endmodule
`default_nettype wire

// File: tb/tb_jt5205_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jt5205_enc                                                        |
// | Randomised bench for jt5205_enc against an arithmetic ADPCM model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jt5205_enc;

  localparam int STEP_INIT = 0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cen;
  logic               sample;
  logic signed [11:0] pcm;
  logic        [3:0]  dout;
  logic               dout_valid;
  logic               busy;
  logic               overrun;
  logic signed [11:0] pred;

  jt5205_enc #(.STEP_INIT(STEP_INIT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .sample     (sample),
    .pcm        (pcm),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .pred       (pred)
  );

  always #5 clk = ~clk;

  int step_tab[49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                       73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                       279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                       963, 1060, 1166, 1282, 1411, 1552};
  int adj_tab[8]   = '{-1, -1, -1, -1, 2, 4, 6, 8};
  int sine_tab[8]  = '{0, 1061, 1500, 1061, 0, -1061, -1500, -1061};

  int n_chk = 0;
  int n_err = 0;

  // Model state: m_* is the encoder's internal view, e_* what the ports should show
  int m_pred, m_idx, pend_nib, pend_pred;
  int age;
  int e_dout, e_pred, e_ovr;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int ref_encode(input int x);
    int st, d, m, q, code, s;
    st   = step_tab[m_idx];
    d    = x - m_pred;
    s    = (d < 0) ? 1 : 0;
    m    = s ? -d : d;
    code = 0;
    q    = st / 8;
    if (m >= st)     begin code += 4; m -= st;     q += st;     end
    if (m >= st / 2) begin code += 2; m -= st / 2; q += st / 2; end
    if (m >= st / 4) begin code += 1;              q += st / 4; end
    m_pred = s ? m_pred - q : m_pred + q;
    if (m_pred > 2047)  m_pred = 2047;
    if (m_pred < -2048) m_pred = -2048;
    m_idx = m_idx + adj_tab[code];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 48) m_idx = 48;
    return s * 8 + code;
  endfunction

  task automatic model_reset();
    m_pred = 0;
    m_idx  = STEP_INIT;
    age    = 0;
    e_dout = 0;
    e_pred = 0;
    e_ovr  = 0;
  endtask

  task automatic check_ports(input string tag);
    check({tag, ".busy"},  busy,          (age != 0) ? 1 : 0);
    check({tag, ".valid"}, dout_valid,    (age == 5) ? 1 : 0);
    check({tag, ".ovr"},   overrun,       e_ovr);
    check({tag, ".dout"},  dout,          e_dout);
    check({tag, ".pred"},  $signed(pred), e_pred);
  endtask

  // One clock: drive inputs, advance the model by one cen cycle, then check
  task automatic step_cycle(input bit c, input bit s, input int x);
    cen    = c;
    sample = s;
    pcm    = 12'(x);
    if (c) begin
      e_ovr = 0;
      if (age != 0) begin
        e_ovr = s ? 1 : 0;
        age   = (age == 5) ? 0 : age + 1;
        if (age == 5) begin
          e_dout = pend_nib;
          e_pred = pend_pred;
        end
      end else if (s) begin
        pend_nib  = ref_encode(x);
        pend_pred = m_pred;
        age       = 1;
      end
    end
    @(posedge clk);
    #1;
    check_ports("cyc");
  endtask

  task automatic enc(input int x);
    step_cycle(1'b1, 1'b1, x);
    repeat (5) step_cycle(1'b1, 1'b0, 0);
  endtask

  initial begin
    rst_n  = 1'b1;
    cen    = 1'b0;
    sample = 1'b0;
    pcm    = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_ports("reset");
    rst_n = 1'b1;
    step_cycle(1'b1, 1'b0, 0);

    // Zero input from reset
    enc(0);
    check("zero.dout", dout, 0);
    check("zero.pred", $signed(pred), 2);

    // Full-scale swings from a fresh reset
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_cycle(1'b1, 1'b0, 0);
    enc(2047);
    check("pos.dout", dout, 7);
    check("pos.pred", $signed(pred), 30);
    enc(-2048);

    // Saturate the index, then decay back
    repeat (20) enc(2047);
    repeat (20) enc(0);

    // Strobe at N+3 is dropped and flagged
    step_cycle(1'b1, 1'b1, 500);
    step_cycle(1'b1, 1'b0, 0);
    step_cycle(1'b1, 1'b0, 0);
    step_cycle(1'b1, 1'b1, -700);
    repeat (3) step_cycle(1'b1, 1'b0, 0);
    // Strobe in the dout_valid cycle is also an overrun
    step_cycle(1'b1, 1'b1, 300);
    repeat (4) step_cycle(1'b1, 1'b0, 0);
    step_cycle(1'b1, 1'b1, 900);
    repeat (6) step_cycle(1'b1, 1'b0, 0);

    // Reset in the middle of an encode
    step_cycle(1'b1, 1'b1, 1000);
    step_cycle(1'b1, 1'b0, 0);
    step_cycle(1'b1, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ports("midrst");
    @(posedge clk);
    #1;
    check_ports("midrst_hold");
    rst_n = 1'b1;
    step_cycle(1'b1, 1'b0, 0);
    enc(0);
    check("after_rst.dout", dout, 0);
    check("after_rst.pred", $signed(pred), 2);

    // Periodic tone
    for (int k = 0; k < 64; k++) enc(sine_tab[k % 8]);

    // Random strobes, PCM and clock-enable gaps
    for (int k = 0; k < 3000; k++) begin
      step_cycle(($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(4) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(4095)) - 2048);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
